// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if
// Bundles the frame-load inputs and the scan outputs of seg_scan_ctrl.
//   digits_in  : BCD frame, digit k at [4k+3:4k], digit 0 rightmost
//   load       : one-cycle strobe capturing digits_in
//   Q          : BCD code of the current slot (to the 7-seg decoder)
//   anode      : active-low digit enables, at most one bit low
//   digit_idx  : index of the current slot
//   frame_done : pulse on the last cycle of the last slot
// Modports: master drives the frame, slave is the scan controller.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    load;
  logic [3:0]              Q;
  logic [NUM_DIGITS-1:0]   anode;
  logic [2:0]              digit_idx;
  logic                    frame_done;

  modport master (
    output digits_in, load,
    input  Q, anode, digit_idx, frame_done
  );

  modport slave (
    input  digits_in, load,
    output Q, anode, digit_idx, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Walks the digit slots of a double-buffered BCD frame; each slot starts with
// BLANK_CYC blank cycles (all anodes off) and then drives the slot's anode.
// Q and digit_idx switch on the edge that starts the blank window so the
// downstream decoder settles before the anode turns on.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seg_scan_ctrl_if.slave (digits_in, load, Q, anode, digit_idx,
//           frame_done)
//
// Optional feature macro: SEG_LZ_BLANK_EN
//   defined     -> leading-zero suppression (digit k dark in DRIVE when it and
//                  all higher digits of the displayed frame are 0; digit 0 is
//                  never suppressed)
//   not defined -> every digit is driven in DRIVE
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  seg_scan_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int DW    = 4 * NUM_DIGITS;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [2:0]            idx_reg, idx_next;
  logic [DW-1:0]         disp_reg, disp_next;
  logic [DW-1:0]         pend_reg, pend_next;
  logic                  pend_v_reg, pend_v_next;
  logic [3:0]            q_reg, q_next;
  logic [NUM_DIGITS-1:0] anode_reg, anode_next;
  logic                  frame_done_reg, frame_done_next;

  logic                  slot_end;
  logic                  frame_end;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  suppressed;

  // Slot/frame sequencing and the tear-free frame buffer swap.
  always_comb begin
    slot_end    = (cnt_reg == CNT_W'(REFRESH_DIV - 1));
    frame_end   = slot_end && (idx_reg == 3'(NUM_DIGITS - 1));
    cnt_next    = slot_end ? '0 : cnt_reg + CNT_W'(1);
    idx_next    = idx_reg;
    disp_next   = disp_reg;
    pend_next   = pend_reg;
    pend_v_next = pend_v_reg;
    state_next  = state_reg;

    if (slot_end) begin
      idx_next = frame_end ? 3'd0 : idx_reg + 3'd1;
    end

    if (frame_end) begin
      // A load landing exactly on the boundary bypasses the pending register.
      if (bus.load) begin
        disp_next   = bus.digits_in;
        pend_v_next = 1'b0;
      end else if (pend_v_reg) begin
        disp_next   = pend_reg;
        pend_v_next = 1'b0;
      end
    end else if (bus.load) begin
      pend_next   = bus.digits_in;
      pend_v_next = 1'b1;
    end

    case (state_reg)
      BLANK:   state_next = (cnt_next == CNT_W'(BLANK_CYC)) ? DRIVE : BLANK;
      DRIVE:   state_next = slot_end ? BLANK : DRIVE;
      default: state_next = BLANK;
    endcase
  end

  // Suppression mask is taken from the frame that will be on screen next
  // cycle, so it only ever changes together with disp at a frame boundary.
`ifdef SEG_LZ_BLANK_EN
  assign lz_mask[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
      assign lz_mask[gi] = ((disp_next >> (4 * gi)) == '0);
    end
  endgenerate
`else
  assign lz_mask = '0;
`endif

  // Output values are computed for the upcoming cycle and registered.
  always_comb begin
    suppressed      = |(lz_mask & (NUM_DIGITS'(1) << idx_next));
    q_next          = 4'(disp_next >> {idx_next, 2'b00});
    anode_next      = '1;
    if (state_next == DRIVE && !suppressed) begin
      anode_next = ~(NUM_DIGITS'(1) << idx_next);
    end
    frame_done_next = (cnt_next == CNT_W'(REFRESH_DIV - 1)) &&
                      (idx_next == 3'(NUM_DIGITS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= BLANK;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      disp_reg       <= '0;
      pend_reg       <= '0;
      pend_v_reg     <= 1'b0;
      q_reg          <= '0;
      anode_reg      <= '1;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      disp_reg       <= disp_next;
      pend_reg       <= pend_next;
      pend_v_reg     <= pend_v_next;
      q_reg          <= q_next;
      anode_reg      <= anode_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign bus.Q          = q_reg;
  assign bus.anode      = anode_reg;
  assign bus.digit_idx  = idx_reg;
  assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
// Scoreboard bench for seg_scan_ctrl (NUM_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYC=2). A reference model derives the expected display purely from
// the number of clock edges since reset and the load history; a monitor pops
// and compares on every falling edge.
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * RD;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .BLANK_CYC  (BC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]    q;
    logic [ND-1:0] an;
    logic [2:0]    idx;
    logic          fd;
  } exp_t;

  exp_t sb[$];

  // Reference model state: edges since reset release, shown and pending frame.
  int          k      = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  bit          m_pv   = 1'b0;

  function automatic exp_t expect_now();
    exp_t e;
    int   slot;
    int   c;
    bit   supp;
    slot   = (k / RD) % ND;
    c      = k % RD;
    e.idx  = 3'(slot);
    e.q    = 4'(m_disp >> (4 * slot));
    e.fd   = (c == RD - 1) && (slot == ND - 1);
    e.an   = '1;
    supp   = 1'b0;
`ifdef SEG_LZ_BLANK_EN
    supp   = (slot != 0) && ((m_disp >> (4 * slot)) == 16'h0);
`endif
    if (c >= BC && !supp) e.an = ~(ND'(1) << slot);
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k      = 0;
      m_disp = '0;
      m_pend = '0;
      m_pv   = 1'b0;
      sb.delete();
    end else begin
      k++;
      if (k % FRAME == 0) begin
        if (bus.load) begin
          m_disp = bus.digits_in;
          m_pv   = 1'b0;
        end else if (m_pv) begin
          m_disp = m_pend;
          m_pv   = 1'b0;
        end
      end else if (bus.load) begin
        m_pend = bus.digits_in;
        m_pv   = 1'b1;
      end
      sb.push_back(expect_now());
    end
  end

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (bus.Q !== e.q || bus.anode !== e.an || bus.digit_idx !== e.idx ||
          bus.frame_done !== e.fd) begin
        errors++;
        $display("FAIL scan k=%0d: got Q=%h anode=%b idx=%0d fd=%b, expected Q=%h anode=%b idx=%0d fd=%b",
                 k, bus.Q, bus.anode, bus.digit_idx, bus.frame_done, e.q, e.an, e.idx, e.fd);
      end
    end
  end

  task automatic check_reset(input string name);
    tests++;
    if (bus.anode !== 4'hF || bus.Q !== 4'h0 || bus.digit_idx !== 3'd0 ||
        bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s: got anode=%b Q=%h idx=%0d fd=%b, expected anode=1111 Q=0 idx=0 fd=0",
               name, bus.anode, bus.Q, bus.digit_idx, bus.frame_done);
    end
  endtask

  // Assumes the caller sits just after a falling edge.
  task automatic pulse_load(input logic [15:0] v);
    bus.digits_in = v;
    bus.load      = 1'b1;
    $display("[TB] load %h at model cycle %0d", v, k);
    @(negedge clk);
    bus.load      = 1'b0;
  endtask

  // mode 0: any anode driven; 1: digit_idx == idx; 2: frame_done high.
  task automatic wait_cond(input int mode, input int idx, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 4 * FRAME && !hit; i++) begin
      @(negedge clk);
      case (mode)
        0:       hit = (bus.anode != 4'hF);
        1:       hit = (bus.digit_idx == 3'(idx));
        default: hit = (bus.frame_done == 1'b1);
      endcase
    end
    if (!hit) begin
      tests++;
      errors++;
      $display("FAIL %s: condition not reached within %0d cycles, required mode %0d", name, 4 * FRAME, mode);
    end
  endtask

  initial begin
    bus.load      = 1'b0;
    bus.digits_in = '0;

    // Reset values while held in reset.
    repeat (2) @(negedge clk);
    check_reset("reset_hold");
    #2 rst_n = 1'b1;
    #1 check_reset("after_release");

    // Scan order with a simple ascending frame.
    @(negedge clk);
    pulse_load(16'h4321);
    repeat (2 * FRAME) @(negedge clk);

    // Asynchronous reset in the middle of a DRIVE window.
    wait_cond(0, 0, "wait_drive");
    #2 rst_n = 1'b0;
    #1 check_reset("reset_mid_drive");
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check_reset("release_again");

    @(negedge clk);
    pulse_load(16'h4321);
    repeat (FRAME) @(negedge clk);

    // Tear-free update: load while slot 1 is active.
    wait_cond(1, 1, "wait_slot1");
    pulse_load(16'h9876);
    repeat (2 * FRAME) @(negedge clk);

    // Double load inside one frame.
    wait_cond(1, 0, "wait_slot0");
    pulse_load(16'h1111);
    repeat (3) @(negedge clk);
    pulse_load(16'h2222);
    repeat (2 * FRAME) @(negedge clk);

    // Load exactly in the frame_done cycle bypasses the pending register.
    wait_cond(2, 0, "wait_frame_done");
    pulse_load(16'h5555);
    repeat (FRAME) @(negedge clk);

    // Leading zeros.
    @(negedge clk);
    pulse_load(16'h0070);
    repeat (2 * FRAME) @(negedge clk);
    pulse_load(16'h0000);
    repeat (2 * FRAME) @(negedge clk);

    // Randomized loads at random spacing, some with zeroed upper digits.
    for (int i = 0; i < 24; i++) begin
      logic [15:0] v;
      repeat ($urandom_range(0, 40)) @(negedge clk);
      v = 16'($urandom);
      if ($urandom_range(0, 2) == 0) v = v >> (4 * $urandom_range(1, 3));
      pulse_load(v);
    end
    repeat (2 * FRAME) @(negedge clk);

    tests++;
    if (sb.size() > 1) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required at most 1", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the board's common-anode seven-segment display. It holds a frame of BCD digits and walks through them one digit slot at a time. For each slot it presents the active digit's 4-bit code on `Q` to the BCD-to-7-segment decoder and drives the matching active-low anode. It sits directly upstream of the decoder: `Q` connects to the decoder's `Q` input, and the decoder's `cathode` output goes to the pins alongside `anode`.

## Interface
- `NUM_DIGITS`, 8: number of display digits (2..8).
- `REFRESH_DIV`, 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz).
- `BLANK_CYC`, 16: cycles at the start of each slot during which all anodes are off (anti-ghosting); must be ≥1 and < `REFRESH_DIV`.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `digits_in`  in  4*NUM_DIGITS  BCD frame; digit k is bits [4k+3:4k]; digit 0 is the rightmost digit.
- `load`  in  1  one-cycle strobe that captures `digits_in` into the pending register.
- `Q`  out  4  BCD code of the current slot, sent to the decoder.
- `anode`  out  NUM_DIGITS  active-low digit enables; at most one bit is low.
- `digit_idx`  out  3  index of the current slot.
- `frame_done`  out  1  one-cycle pulse on the last cycle of slot NUM_DIGITS-1.

## Operation
- Registers:
  - slot counter `cnt` (0..REFRESH_DIV-1);
  - `digit_idx`;
  - display register `disp`;
  - pending register `pend` with flag `pend_v`.
- The FSM has two states, BLANK and DRIVE.
- BLANK:
  - holds while `cnt` < BLANK_CYC;
  - `anode` is all ones;
  - `Q` already carries `disp` digit `digit_idx`.
- DRIVE:
  - holds while `cnt` ≥ BLANK_CYC;
  - `anode[digit_idx]` = 0, all other bits 1, unless the digit is suppressed (see Configuration).
- When `cnt` = REFRESH_DIV-1, `cnt` returns to 0, `digit_idx` advances, and the FSM re-enters BLANK.
- `digit_idx` wraps from NUM_DIGITS-1 to 0. That wrap is the frame boundary.
- `load` behaviour:
  - `pend` <= `digits_in` and `pend_v` <= 1;
  - a later `load` before the boundary overwrites `pend`, and only the last value is displayed.
- Frame boundary update:
  - if `load` is high in the boundary cycle, `disp` <= `digits_in` (bypass) and `pend_v` <= 0;
  - else if `pend_v` is set, `disp` <= `pend` and `pend_v` <= 0;
  - otherwise `disp` is unchanged.
  - This prevents tearing: a frame never mixes old and new digits.
- `Q` passes codes 10..15 through unchanged; the decoder defines their glyph.

## Timing
- Reset values, applied immediately on `rst_n` low:
  - `anode` = all ones;
  - `Q` = 0;
  - `digit_idx` = 0;
  - `frame_done` = 0;
  - `cnt` = 0;
  - `disp` = 0;
  - `pend` = 0;
  - `pend_v` = 0;
  - FSM in BLANK.
- Reset mid-frame discards any pending load.
- All outputs are registered. `Q` and `digit_idx` change on the same edge that starts BLANK, which gives the decoder BLANK_CYC cycles to settle before the anode turns on.
- A new frame is visible starting from the first slot after the next frame boundary. Worst-case latency from `load` to display is NUM_DIGITS*REFRESH_DIV cycles.
- `frame_done` is high exactly in the cycle where `cnt` = REFRESH_DIV-1 and `digit_idx` = NUM_DIGITS-1.
- After `rst_n` deasserts, slot 0 begins with BLANK_CYC blank cycles.

## Configuration
- `SEG_LZ_BLANK_EN` defined: leading-zero suppression.
  - During DRIVE, digit k keeps its anode high if `disp` digit k and every higher digit are all 0.
  - Digit 0 is never suppressed.
  - Suppression is computed from `disp`, so it updates only at frame boundaries.
- `SEG_LZ_BLANK_EN` not defined: every digit is driven in DRIVE, including leading zeros.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2.
- Reset: assert `rst_n`=0 mid-DRIVE -> `anode`=4'b1111, `Q`=0, `digit_idx`=0 in the same cycle. Release -> slot 0 is blank for 2 cycles, then `anode`=4'b1110 for 6 cycles.
- Scan order: load 16'h4321 and wait for the boundary -> `Q` sequence 1,2,3,4; `anode` 1110, 1101, 1011, 0111, each low for 6 of 8 cycles; `frame_done` pulses every 32 cycles.
- Tear-free update: load 16'h9876 while slot 1 is active -> remaining slots still show 3,4; next frame shows 6,7,8,9.
- Double load and boundary bypass:
  - load 16'h1111 then 16'h2222 within one frame -> only 2222 is displayed.
  - `load`=1 with 16'h5555 in the `frame_done` cycle -> 5555 is shown from the very next slot.
- Leading zeros: with `SEG_LZ_BLANK_EN`, frame 16'h0070 -> anodes 3 and 2 stay high, digit 1 shows 7, digit 0 shows 0. Frame 16'h0000 -> only digit 0 is lit. Without the macro, all four digits are lit.
